triangle_cull_arbiter: RTL and testbench

TRIANGLE_CULL_ARBITER -- requirements
Module: triangle_cull_arbiter

---
 rtl/triangle_cull_arbiter.sv | 138 +++++++++++++
 tb/tb_triangle_cull_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/triangle_cull_arbiter.sv
// rtl/triangle_cull_arbiter.sv - round-robin burst arbiter feeding one frustum culler, with per-frame triangle accounting
module triangle_cull_arbiter #(
  parameter int NUM_REQ   = 2,
  parameter int BURST_MAX = 4,
  parameter int TRI_W     = 96
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ*TRI_W-1:0]   req_triangle,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [TRI_W-1:0]           out_triangle,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(NUM_REQ)-1:0] out_src,
  input  logic                       cull_busy,
  output logic                       frame_done,
  output logic [31:0]                frame_tri_count,
  output logic                       busy
);
  localparam int SRC_W = $clog2(NUM_REQ);
  localparam logic [3:0] BURST_LIM = 4'(BURST_MAX);

  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_e;

  state_e             state_q, state_d;
  logic [TRI_W-1:0]   out_tri_q;
  logic               out_valid_q;
  logic [SRC_W-1:0]   out_src_q;
  logic [SRC_W-1:0]   cur_q;
  logic [3:0]         burst_q, burst_d;
  logic [NUM_REQ-1:0] last_seen_q;
  logic [31:0]        tri_cnt_q;
  logic [31:0]        frame_cnt_q;

  logic               stage_free;
  logic               sel_valid;
  logic               xfer;
  logic [SRC_W-1:0]   sel;
  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] others;

  assign stage_free = !out_valid_q || out_ready;
  assign xfer       = (state_q == RUN) && stage_free && sel_valid;

  // Stay on the current lane unless its burst is used up and someone else waits;
  // otherwise rotate to the nearest eligible lane after it.
  always_comb begin
    int idx;
    idx       = 0;
    eligible  = req_valid & ~last_seen_q;
    others    = eligible;
    others[cur_q] = 1'b0;
    sel       = cur_q;
    sel_valid = 1'b0;
    if (eligible[cur_q] && !(burst_q == BURST_LIM && |others)) begin
      sel_valid = 1'b1;
    end else begin
      for (int k = NUM_REQ - 1; k >= 1; k--) begin
        idx = (int'(cur_q) + k) % NUM_REQ;
        if (eligible[idx]) begin
          sel       = SRC_W'(idx);
          sel_valid = 1'b1;
        end
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (rst_n && xfer) req_ready[sel] = 1'b1;
  end

  always_comb begin
    burst_d = 4'd1;
    if (sel == cur_q) burst_d = (burst_q == BURST_LIM) ? burst_q : burst_q + 4'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (&last_seen_q) state_d = DRAIN;
      DRAIN:   if (!out_valid_q && !cull_busy) state_d = DONE;
      DONE:    state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    frame_done = (state_q == DONE);
    busy       = out_valid_q || (state_q != RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_tri_q   <= '0;
      out_valid_q <= 1'b0;
      out_src_q   <= '0;
      cur_q       <= '0;
      burst_q     <= '0;
      last_seen_q <= '0;
      tri_cnt_q   <= '0;
      frame_cnt_q <= '0;
    end else begin
      if (xfer) begin
        out_tri_q   <= req_triangle[int'(sel)*TRI_W +: TRI_W];
        out_src_q   <= sel;
        out_valid_q <= 1'b1;
        cur_q       <= sel;
        burst_q     <= burst_d;
        tri_cnt_q   <= tri_cnt_q + 32'd1;
        if (req_last[sel]) last_seen_q[sel] <= 1'b1;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
      if (state_q == DONE) begin
        frame_cnt_q <= tri_cnt_q;
        tri_cnt_q   <= '0;
        last_seen_q <= '0;
      end
    end
  end

  assign out_triangle    = out_tri_q;
  assign out_valid       = out_valid_q;
  assign out_src         = out_src_q;
  assign frame_tri_count = frame_cnt_q;

endmodule

// File: tb/tb_triangle_cull_arbiter.sv
// tb/tb_triangle_cull_arbiter.sv - randomized self-checking bench for triangle_cull_arbiter
module tb_triangle_cull_arbiter;
  localparam int NUM_REQ   = 2;
  localparam int BURST_MAX = 4;
  localparam int TRI_W     = 32;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic [NUM_REQ*TRI_W-1:0] req_triangle;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_last;
  logic [NUM_REQ-1:0]       req_ready;
  logic [TRI_W-1:0]         out_triangle;
  logic                     out_valid;
  logic                     out_ready;
  logic [0:0]               out_src;
  logic                     cull_busy;
  logic                     frame_done;
  logic [31:0]              frame_tri_count;
  logic                     busy;

  triangle_cull_arbiter #(.NUM_REQ(NUM_REQ), .BURST_MAX(BURST_MAX), .TRI_W(TRI_W)) dut (
    .clk(clk), .rst_n(rst_n), .req_triangle(req_triangle), .req_valid(req_valid),
    .req_last(req_last), .req_ready(req_ready), .out_triangle(out_triangle),
    .out_valid(out_valid), .out_ready(out_ready), .out_src(out_src),
    .cull_busy(cull_busy), .frame_done(frame_done), .frame_tri_count(frame_tri_count),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Lane sources: each lane owes lane_tot triangles this frame, the final one flagged last.
  int lane_tot[NUM_REQ];
  int lane_sent[NUM_REQ];
  int lane_pct[NUM_REQ];
  bit pushy;
  int frame_id = 0;
  int rdy_pct, busy_pct, busy_mode, bz_cnt;
  int cyc = 0;

  // Reference model state.
  bit          m_ov;
  logic [TRI_W-1:0] m_otri;
  int          m_osrc, m_cur, m_run, m_ph;
  bit          m_ls[NUM_REQ];
  logic [31:0] m_tri, m_fcnt;
  bit          m_done;
  int          xlog_src[$];
  int          xlog_cyc[$];
  int          dut_done_cnt;

  function automatic logic [TRI_W-1:0] tri_val(input int lane, input int n);
    return {8'(frame_id), 8'(lane), 16'(n)};
  endfunction

  function automatic bit all_ls();
    for (int i = 0; i < NUM_REQ; i++) if (!m_ls[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int pick(input logic [NUM_REQ-1:0] elig);
    bit others;
    others = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) if (i != m_cur && elig[i]) others = 1'b1;
    if (elig[m_cur] && !(m_run >= BURST_MAX && others)) return m_cur;
    for (int k = 1; k < NUM_REQ; k++) if (elig[(m_cur + k) % NUM_REQ]) return (m_cur + k) % NUM_REQ;
    return -1;
  endfunction

  task automatic drive();
    bit more;
    for (int i = 0; i < NUM_REQ; i++) begin
      more = lane_sent[i] < lane_tot[i];
      req_valid[i] = (more || pushy) && ($urandom_range(99) < lane_pct[i]);
      req_last[i]  = more && (lane_sent[i] == lane_tot[i] - 1);
      req_triangle[i*TRI_W +: TRI_W] = tri_val(i, lane_sent[i]);
    end
    out_ready = (rdy_pct < 0) ? ((cyc % 5) < 2) : ($urandom_range(99) < rdy_pct);
    cull_busy = (busy_mode == 1) ? (bz_cnt < 2) : ($urandom_range(99) < busy_pct);
  endtask

  task automatic model_reset();
    m_ov = 0; m_otri = '0; m_osrc = 0; m_cur = 0; m_run = 0; m_ph = 0;
    m_tri = '0; m_fcnt = '0;
    for (int i = 0; i < NUM_REQ; i++) m_ls[i] = 0;
  endtask

  task automatic begin_frame(input int t0, input int t1, input int p0, input int p1,
                             input int rdy, input int bsy, input int bmode);
    frame_id++;
    lane_tot[0] = t0; lane_tot[1] = t1;
    lane_pct[0] = p0; lane_pct[1] = p1;
    lane_sent[0] = 0; lane_sent[1] = 0;
    rdy_pct = rdy; busy_pct = bsy; busy_mode = bmode;
    pushy = 0; bz_cnt = 0; dut_done_cnt = 0; m_done = 0;
    xlog_src.delete(); xlog_cyc.delete();
    drive();
  endtask

  task automatic step();
    logic [NUM_REQ-1:0] elig, exp_rdy;
    int g;
    bit free_s, xfer;
    @(negedge clk);
    free_s = !m_ov || out_ready;
    for (int i = 0; i < NUM_REQ; i++) elig[i] = req_valid[i] && !m_ls[i];
    g = pick(elig);
    exp_rdy = '0;
    if (m_ph == 0 && free_s && g >= 0) exp_rdy[g] = 1'b1;
    check("req_ready", req_ready, exp_rdy);
    check("out_valid", out_valid, m_ov);
    if (m_ov) begin
      check("out_triangle", out_triangle, m_otri);
      check("out_src", out_src, m_osrc);
    end
    check("frame_done", frame_done, m_ph == 2);
    check("busy", busy, m_ov || m_ph != 0);
    check("frame_tri_count", frame_tri_count, m_fcnt);
    if (frame_done) dut_done_cnt++;
    xfer = exp_rdy != '0;
    @(posedge clk);
    if (m_ph == 2) begin
      m_fcnt = m_tri; m_tri = '0; m_ph = 0; m_done = 1;
      for (int i = 0; i < NUM_REQ; i++) m_ls[i] = 0;
    end else if (m_ph == 1) begin
      if (!m_ov && !cull_busy) m_ph = 2;
      if (!m_ov) bz_cnt++;
    end else if (all_ls()) begin
      m_ph = 1;
    end
    if (xfer) begin
      m_otri = tri_val(g, lane_sent[g]);
      m_osrc = g;
      m_ov   = 1;
      m_run  = (g == m_cur) ? ((m_run < BURST_MAX) ? m_run + 1 : BURST_MAX) : 1;
      m_cur  = g;
      m_tri  = m_tri + 1;
      if (lane_sent[g] == lane_tot[g] - 1) m_ls[g] = 1;
      lane_sent[g]++;
      xlog_src.push_back(g);
      xlog_cyc.push_back(cyc);
    end else if (out_ready) begin
      m_ov = 0;
    end
    cyc++;
    #1 drive();
  endtask

  task automatic wait_frame(input int maxc, input int exp_total);
    for (int c = 0; c < maxc && !m_done; c++) step();
    check("frame_end", m_done, 1);
    check("frame_count", frame_tri_count, exp_total);
    check("done_pulses", dut_done_cnt, 1);
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_triangle"}, out_triangle, 0);
    check({tag, "_out_src"}, out_src, 0);
    check({tag, "_req_ready"}, req_ready, 0);
    check({tag, "_frame_done"}, frame_done, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_frame_count"}, frame_tri_count, 0);
  endtask

  initial begin
    int t0, t1;
    model_reset();
    begin_frame(20, 20, 100, 100, 100, 0, 0);
    #2 reset_checks("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    drive();

    // Both lanes saturated: bursts of BURST_MAX alternate.
    wait_frame(200, 40);
    for (int k = 0; k < 9; k++) check("burst_seq", xlog_src[k], (k / BURST_MAX) % 2);

    // Lane0 alone streams back to back.
    begin_frame(6, 1, 100, 0, 100, 0, 0);
    repeat (8) step();
    check("lane0_xfers", xlog_src.size(), 6);
    for (int k = 0; k < xlog_src.size(); k++) begin
      check("lane0_src", xlog_src[k], 0);
      check("lane0_gap", xlog_cyc[k] - xlog_cyc[0], k);
    end
    lane_pct[1] = 100;
    wait_frame(100, 7);

    // Culler stalls three of every five cycles.
    begin_frame(6, 6, 100, 100, -1, 20, 0);
    wait_frame(300, 12);
    check("stall_xfers", xlog_src.size(), 12);

    // Lane0 finishes early and keeps pushing; culler busy lingers after the final output.
    begin_frame(3, 5, 100, 100, 100, 0, 1);
    pushy = 1;
    drive();
    wait_frame(200, 8);

    // Reset mid-frame with a triangle in flight.
    begin_frame(10, 10, 80, 80, 70, 0, 0);
    for (int c = 0; c < 50 && !m_ov; c++) step();
    check("reset_setup", m_ov, 1);
    #2 rst_n = 1'b0;
    #1 reset_checks("midreset");
    check("aborted_done", dut_done_cnt, 0);
    model_reset();
    @(posedge clk);
    #2 check("reset_hold_ready", req_ready, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    begin_frame(2, 3, 100, 100, 100, 0, 0);
    wait_frame(100, 5);

    // Random traffic, including lanes dropping valid mid-burst.
    for (int f = 0; f < 8; f++) begin
      t0 = $urandom_range(12, 1);
      t1 = $urandom_range(12, 1);
      begin_frame(t0, t1, $urandom_range(100, 30), $urandom_range(100, 30),
                  $urandom_range(100, 40), $urandom_range(70, 0), 0);
      wait_frame(800, t0 + t1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
